// File: rtl/ball_ctrl.sv
// Ball position controller: moves a ball either from debounced-by-sync button
// requests (round-robin served, one per frame) or in autonomous bounce mode.
module ball_ctrl #(
  parameter logic [9:0] H_VALID     = 10'd640,
  parameter logic [9:0] V_VALID     = 10'd480,
  parameter int         BALL_RADIUS = 20,
  parameter int         STEP        = 10
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [3:0] btn_n,
  input  logic       auto_en,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       frame_start,
  output logic       busy
);

  // Limits are held at 11 bits so that pos+STEP and MIN+STEP never wrap.
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] XMIN   = 11'(BALL_RADIUS);
  localparam logic [10:0] XMAX   = {1'b0, H_VALID} - 11'd1 - 11'(BALL_RADIUS);
  localparam logic [10:0] YMIN   = 11'(BALL_RADIUS);
  localparam logic [10:0] YMAX   = {1'b0, V_VALID} - 11'd1 - 11'(BALL_RADIUS);
  localparam logic [9:0]  X_INIT = H_VALID >> 1;
  localparam logic [9:0]  Y_INIT = V_VALID >> 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [3:0] btn_meta;
  logic [3:0] btn_sync;
  logic [3:0] btn_prev;
  logic [3:0] btn_evt;

  logic [3:0] pending;
  logic [3:0] pending_next;
  logic [1:0] rr_ptr;
  logic [1:0] rr_next;

  logic       grant_found;
  logic [1:0] grant_idx;
  logic [1:0] search_idx;

  logic       mode_auto;
  logic       grant_valid;
  logic [1:0] grant_sel;

  logic       dir_x;
  logic       dir_y;
  logic       dir_x_next;
  logic       dir_y_next;
  logic [9:0] x_next;
  logic [9:0] y_next;

  logic       frame_cond;

  function automatic logic [9:0] step_dec(input logic [9:0] pos, input logic [10:0] lim);
    logic [10:0] p;
    p = {1'b0, pos};
    if (p >= lim + STEP_W) step_dec = 10'(p - STEP_W);
    else                   step_dec = lim[9:0];
  endfunction

  function automatic logic [9:0] step_inc(input logic [9:0] pos, input logic [10:0] lim);
    logic [10:0] p;
    p = {1'b0, pos};
    if (p + STEP_W <= lim) step_inc = 10'(p + STEP_W);
    else                   step_inc = lim[9:0];
  endfunction

  assign frame_cond = (pix_x == 10'd0) && (pix_y == V_VALID);
  assign btn_evt    = btn_prev & ~btn_sync;
  assign busy       = (state == ARB) || (state == APPLY);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      btn_meta <= 4'hF;
      btn_sync <= 4'hF;
      btn_prev <= 4'hF;
    end else begin
      btn_meta <= btn_n;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A boundary seen in ARB or APPLY is dropped: only IDLE reacts to it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_cond) state_next = ARB;
      ARB:     state_next = APPLY;
      APPLY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_ptr;
    search_idx  = rr_ptr;
    for (int i = 0; i < 4; i++) begin
      search_idx = rr_ptr + 2'(i);
      if (!grant_found && pending[search_idx]) begin
        grant_found = 1'b1;
        grant_idx   = search_idx;
      end
    end
  end

  // New events are OR-ed in last so a same-cycle press survives its own grant.
  always_comb begin
    pending_next = pending;
    rr_next      = rr_ptr;
    if (state == ARB) begin
      if (auto_en) begin
        pending_next = 4'h0;
      end else if (grant_found) begin
        pending_next[grant_idx] = 1'b0;
        rr_next                 = grant_idx + 2'd1;
      end
    end
    pending_next = pending_next | btn_evt;
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pending     <= 4'h0;
      rr_ptr      <= 2'd0;
      mode_auto   <= 1'b0;
      grant_valid <= 1'b0;
      grant_sel   <= 2'd0;
      frame_start <= 1'b0;
    end else begin
      pending     <= pending_next;
      rr_ptr      <= rr_next;
      frame_start <= frame_cond;
      if (state == ARB) begin
        mode_auto   <= auto_en;
        grant_valid <= !auto_en && grant_found;
        grant_sel   <= grant_idx;
      end
    end
  end

  // An axis landing exactly on a limit keeps its direction; the following
  // frame then sees the step as passing the limit and turns around.
  always_comb begin
    x_next     = ball_x;
    y_next     = ball_y;
    dir_x_next = dir_x;
    dir_y_next = dir_y;
    if (state == APPLY) begin
      if (mode_auto) begin
        if (dir_x) begin
          if ({1'b0, ball_x} + STEP_W > XMAX) begin
            x_next     = XMAX[9:0];
            dir_x_next = 1'b0;
          end else begin
            x_next = 10'({1'b0, ball_x} + STEP_W);
          end
        end else begin
          if ({1'b0, ball_x} < XMIN + STEP_W) begin
            x_next     = XMIN[9:0];
            dir_x_next = 1'b1;
          end else begin
            x_next = 10'({1'b0, ball_x} - STEP_W);
          end
        end
        if (dir_y) begin
          if ({1'b0, ball_y} + STEP_W > YMAX) begin
            y_next     = YMAX[9:0];
            dir_y_next = 1'b0;
          end else begin
            y_next = 10'({1'b0, ball_y} + STEP_W);
          end
        end else begin
          if ({1'b0, ball_y} < YMIN + STEP_W) begin
            y_next     = YMIN[9:0];
            dir_y_next = 1'b1;
          end else begin
            y_next = 10'({1'b0, ball_y} - STEP_W);
          end
        end
      end else if (grant_valid) begin
        case (grant_sel)
          2'd0:    x_next = step_dec(ball_x, XMIN);
          2'd1:    x_next = step_inc(ball_x, XMAX);
          2'd2:    y_next = step_dec(ball_y, YMIN);
          default: y_next = step_inc(ball_y, YMAX);
        endcase
      end
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ball_x <= X_INIT;
      ball_y <= Y_INIT;
      dir_x  <= 1'b1;
      dir_y  <= 1'b1;
    end else begin
      ball_x <= x_next;
      ball_y <= y_next;
      dir_x  <= dir_x_next;
      dir_y  <= dir_y_next;
    end
  end

endmodule
